// File: rtl/line_reader_pkg.sv
// Shared types and helpers for the line reader: FSM state encoding,
// read-latency bounds and the word-index width helper.
package line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    // Number of address bits that select a word inside a line.
    function automatic int log2_words(input int words);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_reader_tag_pipe.sv
// Valid/index tag shift register that tracks reads in flight to the memory,
// so returning data can be steered into the right word of the line.
module read_tag_pipe
    import line_reader_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [IDX_W-1:0] in_idx_i,
    output logic             out_vld_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             empty_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            idx_q[0] <= in_idx_i;
            for (int j = 1; j < DEPTH; j++) begin
                vld_q[j] <= vld_q[j-1];
                idx_q[j] <= idx_q[j-1];
            end
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_idx_o = idx_q[DEPTH-1];

    // High when no valid tag will remain after this edge; the tag leaving
    // the last stage is consumed on that same edge.
    always_comb begin
        empty_o = !in_vld_i;
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (vld_q[j]) empty_o = 1'b0;
        end
    end

endmodule

// File: rtl/line_reader.sv
// Reads one memory line, critical word first with wrap inside the line,
// and holds the assembled line until the consumer takes it.
module line_reader
    import line_reader_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WORDS    = 4,
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    req_ready,
    output logic [ADDR_W-1:0]       mem_address,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    rsp_valid,
    output logic [WORDS*DATA_W-1:0] rsp_line,
    input  logic                    rsp_ready
);

    localparam int IDX_W  = log2_words(WORDS);
    localparam int BASE_W = ADDR_W - IDX_W;

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("line_reader: READ_LAT out of range");
    end
    if (WORDS < 2 || (1 << IDX_W) != WORDS) begin : g_bad_words
        $error("line_reader: WORDS must be a power of two >= 2");
    end

    state_e                        state_q, state_d;
    logic [BASE_W-1:0]             base_q, base_d;
    logic [IDX_W-1:0]              idx0_q, idx0_d;
    logic [IDX_W-1:0]              k_q, k_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          iss_vld_q, iss_vld_d;
    logic [IDX_W-1:0]              iss_idx_q, iss_idx_d;
    logic [WORDS-1:0][DATA_W-1:0]  line_q;

    logic [IDX_W-1:0] cur_idx;
    logic             wr_vld;
    logic [IDX_W-1:0] wr_idx;
    logic             pipe_empty;

    // The issue tag register sits alongside mem_address, so the pipe behind
    // it only has to cover the device latency.
    read_tag_pipe #(
        .DEPTH (READ_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (iss_vld_q),
        .in_idx_i  (iss_idx_q),
        .out_vld_o (wr_vld),
        .out_idx_o (wr_idx),
        .empty_o   (pipe_empty)
    );

    assign cur_idx = idx0_q + k_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx0_d    = idx0_q;
        k_d       = k_q;
        addr_d    = addr_q;
        iss_vld_d = 1'b0;
        iss_idx_d = iss_idx_q;
        unique case (state_q)
            IDLE: begin
                // The critical word goes out on the accepting edge itself.
                if (req_valid) begin
                    base_d    = req_addr[ADDR_W-1:IDX_W];
                    idx0_d    = req_addr[IDX_W-1:0];
                    k_d       = IDX_W'(1);
                    addr_d    = req_addr;
                    iss_vld_d = 1'b1;
                    iss_idx_d = req_addr[IDX_W-1:0];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                addr_d    = {base_q, cur_idx};
                iss_vld_d = 1'b1;
                iss_idx_d = cur_idx;
                k_d       = k_q + IDX_W'(1);
                if (k_q == IDX_W'(WORDS - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            idx0_q    <= '0;
            k_q       <= '0;
            addr_q    <= '0;
            iss_vld_q <= 1'b0;
            iss_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx0_q    <= idx0_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            iss_vld_q <= iss_vld_d;
            iss_idx_q <= iss_idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (wr_vld) begin
            line_q[wr_idx] <= mem_data;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == HOLD);
    assign mem_address = addr_q;
    assign rsp_line    = line_q;

endmodule
